// File: rtl/cache_sram_pkg.sv
// Shared constants and types for the cache data SRAM read-side blocks.
// Geometry: 512 sets x 4 banks x 32-bit words.
package cache_sram_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int NBANK  = 4;
    localparam int BEAT_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CAP,
        SEND
    } state_t;

    typedef logic [DATA_W-1:0] word_t;
    typedef word_t [NBANK-1:0] line_t;

endpackage

// File: rtl/sram_line_evict_reader_if.sv
// Bundle of request, array read, write-snoop and beat-stream signals.
// master = the evict reader, slave = array + requester + downstream.
interface sram_line_evict_reader_if;
    import cache_sram_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_set;

    logic [ADDR_W-1:0] arr_r_addr;
    word_t             arr_r_data_0;
    word_t             arr_r_data_1;
    word_t             arr_r_data_2;
    word_t             arr_r_data_3;

    logic              snp_w_en;
    logic [ADDR_W-1:0] snp_w_addr;
    word_t             snp_w_data_0;
    word_t             snp_w_data_1;
    word_t             snp_w_data_2;
    word_t             snp_w_data_3;
    logic [NBANK-1:0]  snp_w_maskOH;

    logic              out_valid;
    logic              out_ready;
    word_t             out_data;
    logic [BEAT_W-1:0] out_beat;
    logic              out_last;
    logic              busy;

    modport master (
        input  req_valid, req_set,
        input  arr_r_data_0, arr_r_data_1,
        input  arr_r_data_2, arr_r_data_3,
        input  snp_w_en, snp_w_addr, snp_w_maskOH,
        input  snp_w_data_0, snp_w_data_1,
        input  snp_w_data_2, snp_w_data_3,
        input  out_ready,
        output req_ready, arr_r_addr,
        output out_valid, out_data, out_beat,
        output out_last, busy
    );

    modport slave (
        output req_valid, req_set,
        output arr_r_data_0, arr_r_data_1,
        output arr_r_data_2, arr_r_data_3,
        output snp_w_en, snp_w_addr, snp_w_maskOH,
        output snp_w_data_0, snp_w_data_1,
        output snp_w_data_2, snp_w_data_3,
        output out_ready,
        input  req_ready, arr_r_addr,
        input  out_valid, out_data, out_beat,
        input  out_last, busy
    );

endinterface

// File: rtl/line_buf_merge.sv
// Line buffer with RD-cycle forwarding and CAP/SEND write-snoop merging.
// Words already accepted downstream are never touched.
module line_buf_merge
    import cache_sram_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              fire,
    input  state_t            state,
    input  logic [BEAT_W-1:0] cnt,
    input  logic [ADDR_W-1:0] set_q,
    input  line_t             arr_data,
    input  logic              snp_en,
    input  logic [ADDR_W-1:0] snp_addr,
    input  line_t             snp_data,
    input  logic [NBANK-1:0]  snp_mask,
    output line_t             line
);

    line_t            line_q;
    line_t            fwd_d;
    logic [NBANK-1:0] fwd_v;
    logic [NBANK-1:0] cov;

    assign cov  = (snp_en && snp_addr == set_q) ? snp_mask : '0;
    assign line = line_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            line_q <= '0;
            fwd_d  <= '0;
            fwd_v  <= '0;
        end else begin
            if (start) fwd_v <= '0;
            for (int i = 0; i < NBANK; i++) begin
                unique case (state)
                    RD: begin
                        // array read-during-write order is undefined
                        if (cov[i]) begin
                            fwd_v[i] <= 1'b1;
                            fwd_d[i] <= snp_data[i];
                        end
                    end
                    CAP: begin
                        if (cov[i])
                            line_q[i] <= snp_data[i];
                        else if (fwd_v[i])
                            line_q[i] <= fwd_d[i];
                        else
                            line_q[i] <= arr_data[i];
                    end
                    SEND: begin
                        if (cov[i] && (i > int'(cnt) ||
                            (i == int'(cnt) && !fire)))
                            line_q[i] <= snp_data[i];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/sram_line_evict_reader.sv
// Evict-read master: one array read per set, then four valid/ready beats.
// FSM and beat counter live here; buffering/merging is in line_buf_merge.
module sram_line_evict_reader
    import cache_sram_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    sram_line_evict_reader_if.master   bus
);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] set_q;
    logic [BEAT_W-1:0] cnt;
    line_t             arr_data;
    line_t             snp_data;
    line_t             line;
    logic              start;
    logic              fire;
    logic              last;

    assign arr_data = {bus.arr_r_data_3, bus.arr_r_data_2,
                       bus.arr_r_data_1, bus.arr_r_data_0};
    assign snp_data = {bus.snp_w_data_3, bus.snp_w_data_2,
                       bus.snp_w_data_1, bus.snp_w_data_0};

    assign start = bus.req_valid && state == IDLE;
    assign fire  = state == SEND && bus.out_ready;
    assign last  = cnt == BEAT_W'(NBANK - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            set_q <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (start) begin
                set_q <= bus.req_set;
                cnt   <= '0;
            end else if (fire) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_n       = state;
        bus.req_ready = state == IDLE;
        bus.busy      = state != IDLE;
        bus.out_valid = state == SEND;
        bus.out_data  = '0;
        bus.out_beat  = cnt;
        bus.out_last  = 1'b0;
        bus.arr_r_addr = set_q;
        unique case (state)
            IDLE: if (start) state_n = RD;
            RD:   state_n = CAP;
            CAP:  state_n = SEND;
            SEND: begin
                bus.out_data = line[cnt];
                bus.out_last = last;
                if (fire && last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    line_buf_merge u_buf (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .fire     (fire),
        .state    (state),
        .cnt      (cnt),
        .set_q    (set_q),
        .arr_data (arr_data),
        .snp_en   (bus.snp_w_en),
        .snp_addr (bus.snp_w_addr),
        .snp_data (snp_data),
        .snp_mask (bus.snp_w_maskOH),
        .line     (line)
    );

endmodule

// File: tb/tb_sram_line_evict_reader.sv
// Scoreboard bench: each beat must equal the array word as of its handshake.
// The array model commits snoop writes and serves one-cycle reads.
module tb_sram_line_evict_reader;
    import cache_sram_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    sram_line_evict_reader_if bus ();

    sram_line_evict_reader dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [8:0] s;
        int         b;
    } sb_t;

    sb_t         sb[$];
    bit          rdy_pat[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hs = 0;
    int          exp_first = -1;
    logic [31:0] mem [512][4];
    logic [31:0] rd [4];
    logic [31:0] got [4];
    logic [31:0] base [4];
    bit          rnd_rdy = 0;
    bit          rnd_snp = 0;
    logic [8:0]  cur_set = '0;

    assign bus.arr_r_data_0 = rd[0];
    assign bus.arr_r_data_1 = rd[1];
    assign bus.arr_r_data_2 = rd[2];
    assign bus.arr_r_data_3 = rd[3];

    always @(posedge clock)
        for (int i = 0; i < 4; i++) rd[i] <= mem[bus.arr_r_addr][i];

    initial forever @(posedge clock) cyc++;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic logic [31:0] snp_word(input int i);
        case (i)
            0: return bus.snp_w_data_0;
            1: return bus.snp_w_data_1;
            2: return bus.snp_w_data_2;
            default: return bus.snp_w_data_3;
        endcase
    endfunction

    task automatic set_snp(input logic [8:0] a, input logic [3:0] m,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
        bus.snp_w_en     = 1'b1;
        bus.snp_w_addr   = a;
        bus.snp_w_maskOH = m;
        bus.snp_w_data_0 = d0;
        bus.snp_w_data_1 = d1;
        bus.snp_w_data_2 = d2;
        bus.snp_w_data_3 = d3;
    endtask

    // commit last cycle's write, then drive this cycle's inputs
    task automatic tick();
        @(posedge clock);
        #1;
        if (bus.snp_w_en)
            for (int i = 0; i < 4; i++)
                if (bus.snp_w_maskOH[i])
                    mem[bus.snp_w_addr][i] = snp_word(i);
        bus.snp_w_en = 1'b0;
        if (rdy_pat.size() > 0)
            bus.out_ready = rdy_pat.pop_front();
        else
            bus.out_ready = rnd_rdy ? 1'($urandom) : 1'b1;
        if (rnd_snp && $urandom_range(2) == 0)
            set_snp(($urandom_range(1) != 0) ? cur_set
                                             : 9'($urandom_range(3)),
                    4'($urandom), $urandom, $urandom,
                    $urandom, $urandom);
    endtask

    task automatic run_req(input logic [8:0] s, input bit hold,
                           input logic [8:0] nxt,
                           input int o1, input logic [8:0] a1,
                           input logic [3:0] m1, input logic [31:0] d1,
                           input int o2, input logic [8:0] a2,
                           input logic [3:0] m2, input logic [31:0] d2,
                           output int occ);
        int k;
        occ = -1;
        cur_set = s;
        bus.req_valid = 1'b1;
        bus.req_set = s;
        k = 0;
        while (!bus.req_ready && k < 50) begin
            tick();
            k++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        tick();
        bus.req_valid = hold;
        if (hold) bus.req_set = nxt;
        for (k = 1; k < 300; k++) begin
            if (bus.req_ready) begin
                occ = k;
                break;
            end
            if (k == o1) set_snp(a1, m1, d1, d1, d1, d1);
            if (k == o2) set_snp(a2, m2, d2, d2, d2, d2);
            tick();
        end
        if (occ < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic load5();
        for (int i = 0; i < 4; i++) mem[5][i] = base[i];
    endtask

    // monitor / scoreboard
    initial begin
        sb_t        e;
        bit         pv;
        bit         pr;
        logic [1:0] pb;
        pv = 0;
        pr = 0;
        pb = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                sb.delete();
                pv = 0;
                exp_first = -1;
            end else begin
                chk("busy", bus.busy, !bus.req_ready);
                if (bus.req_valid && bus.req_ready) begin
                    for (int b = 0; b < 4; b++)
                        sb.push_back('{s: bus.req_set, b: b});
                    exp_first = cyc + 3;
                end
                if (bus.out_valid && !pv)
                    chk("latency", cyc, exp_first);
                if (pv && !pr) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_beat", bus.out_beat, pb);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 0, 1);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_idx", bus.out_beat, e.b);
                        chk("beat_last", bus.out_last, e.b == 3);
                        chk("beat_data", bus.out_data, mem[e.s][e.b]);
                        got[e.b] = bus.out_data;
                        hs++;
                    end
                end
                pv = bus.out_valid;
                pr = bus.out_ready;
                pb = bus.out_beat;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          occ;
        int          h0;
        logic [31:0] e1 [4];
        logic [31:0] e0 [4];
        logic [8:0]  s;
        base = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        bus.req_valid = 0;
        bus.req_set = '0;
        bus.snp_w_en = 0;
        bus.snp_w_addr = '0;
        bus.snp_w_maskOH = '0;
        bus.snp_w_data_0 = '0;
        bus.snp_w_data_1 = '0;
        bus.snp_w_data_2 = '0;
        bus.snp_w_data_3 = '0;
        bus.out_ready = 1'b1;
        for (int a = 0; a < 512; a++)
            for (int i = 0; i < 4; i++) mem[a][i] = $urandom;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_arr_addr", bus.arr_r_addr, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_beat", bus.out_beat, 0);
        chk("rst_out_last", bus.out_last, 0);
        reset = 1'b1;
        tick();

        load5();
        h0 = hs;
        run_req(9'h005, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, occ);
        chk("basic_occ", occ, 7);
        chk("basic_beats", hs - h0, 4);
        for (int i = 0; i < 4; i++) chk("basic_data", got[i], base[i]);

        load5();
        h0 = hs;
        rdy_pat = '{1, 1, 1, 0, 0, 1, 0, 1, 1};
        run_req(9'h005, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, occ);
        chk("bp_occ", occ, 10);
        chk("bp_beats", hs - h0, 4);
        for (int i = 0; i < 4; i++) chk("bp_data", got[i], base[i]);

        load5();
        run_req(9'h005, 0, 0, 1, 9'h005, 4'b0100, 32'hDEADBEEF,
                0, 0, 0, 0, occ);
        chk("fwd_b2", got[2], 32'hDEADBEEF);
        chk("fwd_b0", got[0], base[0]);
        chk("fwd_b1", got[1], base[1]);
        chk("fwd_b3", got[3], base[3]);

        load5();
        rdy_pat = '{1, 1, 1, 0, 0, 1, 1, 1};
        run_req(9'h005, 0, 0, 4, 9'h005, 4'b1011, 32'hA5A5A5A5,
                5, 9'h006, 4'hF, 32'h12345678, occ);
        chk("merge_occ", occ, 9);
        chk("merge_b0", got[0], base[0]);
        chk("merge_b1", got[1], 32'hA5A5A5A5);
        chk("merge_b2", got[2], base[2]);
        chk("merge_b3", got[3], 32'hA5A5A5A5);

        load5();
        h0 = hs;
        bus.req_valid = 1'b1;
        bus.req_set = 9'h005;
        tick();
        bus.req_valid = 1'b0;
        repeat (4) tick();
        chk("rst_mid_beats", hs - h0, 2);
        reset = 1'b0;
        #1;
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_ready", bus.req_ready, 1);
        chk("rst_mid_addr", bus.arr_r_addr, 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        h0 = hs;
        run_req(9'h005, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, occ);
        chk("post_rst_occ", occ, 7);
        chk("post_rst_beats", hs - h0, 4);
        for (int i = 0; i < 4; i++) chk("post_rst_data", got[i], base[i]);

        for (int i = 0; i < 4; i++) begin
            e1[i] = mem[511][i];
            e0[i] = mem[0][i];
        end
        run_req(9'h1FF, 1, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0, occ);
        chk("b2b_occ", occ, 7);
        for (int i = 0; i < 4; i++) chk("b2b_1ff", got[i], e1[i]);
        run_req(9'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, occ);
        chk("b2b_occ0", occ, 7);
        for (int i = 0; i < 4; i++) chk("b2b_000", got[i], e0[i]);

        rnd_rdy = 1;
        rnd_snp = 1;
        repeat (40) begin
            s = ($urandom_range(4) == 4) ? 9'h1FF : 9'($urandom_range(3));
            run_req(s, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, occ);
        end
        rnd_snp = 0;
        rnd_rdy = 0;
        repeat (3) tick();
        chk("sb_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_line_evict_reader.md
Name: sram_line_evict_reader

Overview:
- Read-side master for the 4-bank, 2-port cache data SRAM array (9-bit set index, four 32-bit banks, one-cycle synchronous read).
- On a request for one set, it issues a single array read and captures all four words into a line buffer. It then streams the words out as four valid/ready beats to the writeback/evict path.
- It snoops the array write port so the streamed line always reflects writes that land on the same set during the operation.

Parameters:
- ADDR_W, 9, set index width (array depth 512)
- DATA_W, 32, bank word width
- NBANK, 4, banks per line = beats per line (fixed power of two)
- BEAT_W, 2, log2(NBANK)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted low clears all state immediately
- req_valid  in  1  evict-read request
- req_ready  out  1  high only in IDLE
- req_set  in  ADDR_W  set index to read
- arr_r_addr  out  ADDR_W  array read address
- arr_r_data_0..3  in  DATA_W each  array read data, valid the cycle after the address
- snp_w_en  in  1  array write enable (tap of the array write port)
- snp_w_addr  in  ADDR_W  array write address
- snp_w_data_0..3  in  DATA_W each  array write data
- snp_w_maskOH  in  NBANK  per-bank write mask
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  beat word
- out_beat  out  BEAT_W  word index of the beat
- out_last  out  1  high on beat NBANK-1
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: state IDLE, set_q 0, beat counter 0, line buffer 0. Outputs at reset: req_ready 1, arr_r_addr 0, out_valid 0, out_data 0, out_beat 0, out_last 0, busy 0.
- FSM states: IDLE, RD, CAP, SEND.
- IDLE -> RD when req_valid && req_ready. In that cycle set_q <= req_set and the beat counter <= 0.
- RD lasts exactly 1 cycle. arr_r_addr = set_q (registered; arr_r_addr holds set_q in every state, including IDLE). RD -> CAP.
- CAP lasts exactly 1 cycle. The buffer latches arr_r_data_i, with snoop overrides applied as described below. CAP -> SEND.
- SEND: out_valid = 1, out_data = buf[cnt], out_beat = cnt, out_last = (cnt == NBANK-1).
  - On out_valid && out_ready: cnt increments. On the last beat, cnt wraps to 0 and the FSM goes SEND -> IDLE.
  - Data and beat index stay stable while stalled.
- Latency: request accepted at cycle T -> first out_valid at T+3. Minimum occupancy is NBANK+2 cycles after acceptance. No back-to-back overlap: req_ready is low from T+1 until the cycle after the last handshake.
- Snoop hit = snp_w_en && snp_w_addr == set_q. Bank i is covered when snp_w_maskOH[i] = 1.
- Hit during RD: read-during-write ordering of the array is not relied upon. Covered banks record fwd_v[i] = 1 and fwd_d[i] = snp_w_data_i. In CAP, buf[i] takes fwd_d[i] when fwd_v[i] is set, otherwise arr_r_data_i.
- Hit during CAP: covered banks take snp_w_data_i, which has priority over the RD forward and over the array data.
- Hit during SEND: covered banks with index > cnt, or == cnt but not handshaking this cycle, are updated in buf. Words already sent are unaffected.
  - A same-cycle hit on the beat being presented updates out_data from the next cycle only, and only if that beat is not accepted this cycle.
- Snoop during IDLE is ignored. fwd_v is cleared on every entry to RD.
- A multi-bit maskOH is legal: each set bit is handled independently.
- Reset asserted mid-operation aborts immediately, with no partial beats after release. out_valid drops asynchronously with reset.
- out_valid must not drop in SEND without a handshake.

Decomposition:
- Shared package cache_sram_pkg: ADDR_W, DATA_W, NBANK, BEAT_W constants; FSM state enum (IDLE/RD/CAP/SEND); line_t typedef (array of NBANK words).
- One sub-module is natural: line_buf_merge. It holds the NBANK-word buffer plus the fwd_v/fwd_d registers and applies the capture/snoop update rules. The top holds the FSM, the counter and the handshakes.

Test Plan:
- Basic evict: array set 0x05 preloaded {0x11111111, 0x22222222, 0x33333333, 0x44444444}; req_set=0x05 at T, out_ready=1 -> beats 0..3 at T+3..T+6 with those values, out_last only at T+6, req_ready high again at T+7.
- Backpressure: same line; out_ready toggles 1,0,0,1,0,1,1 -> each beat held stable while out_ready=0; exactly 4 handshakes in order; busy drops after the last handshake.
- RD-cycle forward: snoop write set 0x05, maskOH=0b0100, data_2=0xDEADBEEF in the RD cycle -> beat 2 = 0xDEADBEEF; beats 0, 1, 3 = array values.
- SEND merge: during SEND with beat 1 stalled, snoop write set 0x05, maskOH=0b1011, all data 0xA5A5A5A5 -> beat 0 (already sent) unchanged; beats 1 and 3 = 0xA5A5A5A5; beat 2 original. A snoop to set 0x06 changes nothing.
- Reset mid-stream: assert reset low after beat 1 handshake -> out_valid=0, req_ready=1, arr_r_addr=0 immediately. A new request after release streams a full line from beat 0.
- Back-to-back: req_valid held high with sets 0x1FF then 0x000 -> second request accepted only when req_ready returns. Both lines correct, including the wrap of the set index to 0x000.
